// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM state codes,
// default bus widths and the slave address map used by the decoder.
package bus_pkg;

    // Arbiter ownership states
    typedef enum logic {
        M0_GNT = 1'b0,
        M1_GNT = 1'b1
    } bus_state_e;

    // Default shared-bus widths
    localparam int unsigned BUS_ADDR_W = 16;
    localparam int unsigned BUS_DATA_W = 32;

    // Slave address map (inclusive ranges)
    localparam logic [15:0] S0_BASE = 16'h0000;
    localparam logic [15:0] S0_LAST = 16'h07FF;
    localparam logic [15:0] S1_BASE = 16'h7000;
    localparam logic [15:0] S1_LAST = 16'h71FF;

    // True when addr falls in slave 0's window
    function automatic logic hits_s0(input logic [15:0] addr);
        return (addr >= S0_BASE) && (addr <= S0_LAST);
    endfunction

    // True when addr falls in slave 1's window
    function automatic logic hits_s1(input logic [15:0] addr);
        return (addr >= S1_BASE) && (addr <= S1_LAST);
    endfunction

endpackage

// File: rtl/bus_mux2.sv
// Parameterised-width 2:1 multiplexer used to steer the granted master
// onto the shared bus.
module bus_mux2 #(
    parameter int unsigned W = 1
) (
    input  logic         sel,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    output logic [W-1:0] out
);

    // sel=0 picks in0, sel=1 picks in1
    always_comb begin
        out = sel ? in1 : in0;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with integrated shared-bus multiplexer.
// Bus parks on master 0 when idle; the current owner keeps the bus while
// it requests. Optional feature macro: BUS_ARBITER_TIMEOUT_EN adds a burst
// counter that forces a hand-over after MAX_BURST contended cycles.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W    = BUS_ADDR_W,
    parameter int unsigned DATA_W    = BUS_DATA_W,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_dout
);

    // Reject out-of-range burst limits at elaboration
    if (MAX_BURST < 2 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("bus_arbiter: MAX_BURST must be within 2..255");
    end

    bus_state_e state_q, state_d;
    logic       m0_grant_q, m1_grant_q;
    logic       own_req, oth_req;
    logic       sel_m1;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_hit;
`endif

    // Owner / challenger request view for the current state
    always_comb begin
        own_req = (state_q == M1_GNT) ? m1_req : m0_req;
        oth_req = (state_q == M1_GNT) ? m0_req : m1_req;
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    // Hand-over is forced once the owner has held a contended bus long enough
    always_comb begin
        timeout_hit = own_req && oth_req && (cnt_q == CNT_LIMIT);
    end
`endif

    // Next-state decision
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            M0_GNT: begin
                if (!m0_req && m1_req) begin
                    state_d = M1_GNT;
                end
`ifdef BUS_ARBITER_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = M1_GNT;
                end
`endif
            end
            M1_GNT: begin
                if (!m1_req) begin
                    state_d = M0_GNT;
                end
`ifdef BUS_ARBITER_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = M0_GNT;
                end
`endif
            end
            default: state_d = M0_GNT;
        endcase
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    // Burst counter: counts contended owner cycles, clears on hand-over or idle owner
    always_comb begin
        cnt_d = '0;
        if (state_d == state_q && own_req && oth_req) begin
            cnt_d = cnt_q + 1'b1;
        end
    end
`endif

    // State register with registered one-hot grants
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= M0_GNT;
            m0_grant_q <= 1'b1;
            m1_grant_q <= 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            m0_grant_q <= (state_d == M0_GNT);
            m1_grant_q <= (state_d == M1_GNT);
`ifdef BUS_ARBITER_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Mux select from registered ownership
    always_comb begin
        sel_m1 = (state_q == M1_GNT);
    end

    assign m0_grant = m0_grant_q;
    assign m1_grant = m1_grant_q;

    bus_mux2 #(.W(1)) u_mux_req (
        .sel (sel_m1),
        .in0 (m0_req),
        .in1 (m1_req),
        .out (m_req)
    );

    bus_mux2 #(.W(1)) u_mux_wr (
        .sel (sel_m1),
        .in0 (m0_wr),
        .in1 (m1_wr),
        .out (m_wr)
    );

    bus_mux2 #(.W(ADDR_W)) u_mux_address (
        .sel (sel_m1),
        .in0 (m0_address),
        .in1 (m1_address),
        .out (m_address)
    );

    bus_mux2 #(.W(DATA_W)) u_mux_dout (
        .sel (sel_m1),
        .in0 (m0_dout),
        .in1 (m1_dout),
        .out (m_dout)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter.
module tb_bus_arbiter;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              m0_req, m0_wr, m1_req, m1_wr;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [DATA_W-1:0] m0_dout, m1_dout;
    logic              m0_grant, m1_grant, m_req, m_wr;
    logic [ADDR_W-1:0] m_address;
    logic [DATA_W-1:0] m_dout;

    int checks   = 0;
    int failures = 0;

    bus_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .m0_req     (m0_req),
        .m0_wr      (m0_wr),
        .m0_address (m0_address),
        .m0_dout    (m0_dout),
        .m1_req     (m1_req),
        .m1_wr      (m1_wr),
        .m1_address (m1_address),
        .m1_dout    (m1_dout),
        .m0_grant   (m0_grant),
        .m1_grant   (m1_grant),
        .m_req      (m_req),
        .m_wr       (m_wr),
        .m_address  (m_address),
        .m_dout     (m_dout)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (m0_grant !== 1'b1 || m1_grant !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold[%0d]: got g0=%b g1=%b, want g0=1 g1=0", i, m0_grant, m1_grant);
            end
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (m0_grant !== 1'b0 || m1_grant !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: got g0=%b g1=%b, want g0=0 g1=1", m0_grant, m1_grant);
        end
    endtask

    task automatic test_handover();
        m1_req = 1'b0;
        step();
        checks++;
        if (m0_grant !== 1'b1 || m_req !== 1'b0) begin
            failures++;
            $display("FAIL park_m0: got g0=%b m_req=%b, want g0=1 m_req=0", m0_grant, m_req);
        end
        m1_req = 1'b1; m1_wr = 1'b1; m1_address = 16'h7004; m1_dout = 32'hCAFE_0001;
        #1;
        checks++;
        if (m1_grant !== 1'b0 || m_req !== 1'b0) begin
            failures++;
            $display("FAIL grant_latency: got g1=%b m_req=%b, want g1=0 m_req=0", m1_grant, m_req);
        end
        step();
        checks++;
        if (m1_grant !== 1'b1 || m_address !== 16'h7004 || m_wr !== 1'b1 || m_req !== 1'b1
            || m_dout !== 32'hCAFE_0001) begin
            failures++;
            $display("FAIL handover_m1: got g1=%b addr=%h wr=%b req=%b dout=%h, want 1 7004 1 1 cafe0001",
                     m1_grant, m_address, m_wr, m_req, m_dout);
        end
        m1_req = 1'b0;
        #1;
        checks++;
        if (m_req !== 1'b0 || m1_grant !== 1'b1) begin
            failures++;
            $display("FAIL idle_owner_req: got m_req=%b g1=%b, want m_req=0 g1=1", m_req, m1_grant);
        end
        step();
        checks++;
        if (m0_grant !== 1'b1 || m1_grant !== 1'b0 || m_req !== 1'b0) begin
            failures++;
            $display("FAIL return_park: got g0=%b g1=%b m_req=%b, want 1 0 0", m0_grant, m1_grant, m_req);
        end
    endtask

    task automatic test_simultaneous();
        m0_req = 1'b1; m0_address = 16'h0010; m0_dout = 32'h0000_A5A5; m0_wr = 1'b0;
        m1_req = 1'b1; m1_address = 16'h7100;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (m0_grant !== 1'b1 || m1_grant !== 1'b0 || m_address !== 16'h0010) begin
                failures++;
                $display("FAIL simultaneous[%0d]: got g0=%b g1=%b addr=%h, want 1 0 0010",
                         i, m0_grant, m1_grant, m_address);
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step();
    endtask

    task automatic test_isolation();
        m0_req = 1'b1; m0_wr = 1'b1; m0_address = 16'h0123; m0_dout = 32'h1234_5678;
        m1_req = 1'b0; m1_wr = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            m1_address = 16'($urandom);
            m1_dout    = $urandom;
            m1_wr      = ~m1_wr;
            #1;
            checks++;
            if (m_address !== 16'h0123 || m_dout !== 32'h1234_5678 || m_wr !== 1'b1 || m0_grant !== 1'b1) begin
                failures++;
                $display("FAIL isolation[%0d]: got addr=%h dout=%h wr=%b g0=%b, want 0123 12345678 1 1",
                         i, m_address, m_dout, m_wr, m0_grant);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_burst();
        m0_req = 1'b0; m1_req = 1'b1;
        step();
        checks++;
        if (m1_grant !== 1'b1) begin
            failures++;
            $display("FAIL mid_burst_enter: got g1=%b, want 1", m1_grant);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++;
        if (m0_grant !== 1'b1 || m1_grant !== 1'b0) begin
            failures++;
            $display("FAIL mid_burst_reset: got g0=%b g1=%b, want 1 0", m0_grant, m1_grant);
        end
    endtask

    task automatic test_back_to_back();
        // m1_req still high from before: regains the bus after reset
        step();
        checks++;
        if (m1_grant !== 1'b1) begin
            failures++;
            $display("FAIL b2b_m1: got g1=%b, want 1", m1_grant);
        end
        // owner drops while m0 requests: return to m0
        m1_req = 1'b0; m0_req = 1'b1; m0_address = 16'h0400;
        step();
        checks++;
        if (m0_grant !== 1'b1 || m_address !== 16'h0400 || m_req !== 1'b1) begin
            failures++;
            $display("FAIL b2b_m0: got g0=%b addr=%h req=%b, want 1 0400 1", m0_grant, m_address, m_req);
        end
        // m0 drops, m1 asks immediately
        m0_req = 1'b0; m1_req = 1'b1; m1_address = 16'h71FF;
        step();
        checks++;
        if (m1_grant !== 1'b1 || m_address !== 16'h71FF) begin
            failures++;
            $display("FAIL b2b_m1_again: got g1=%b addr=%h, want 1 71ff", m1_grant, m_address);
        end
        // both requesting with m1 as owner: m1 keeps it
        m0_req = 1'b1;
        step();
        checks++;
        if (m1_grant !== 1'b1 || m0_grant !== 1'b0) begin
            failures++;
            $display("FAIL b2b_owner_keeps: got g0=%b g1=%b, want 0 1", m0_grant, m1_grant);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        step();
    endtask

`ifdef BUS_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if (m1_grant !== ((i >= 4 && i < 8) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL timeout[%0d]: got g1=%b, want %b", i, m1_grant, (i >= 4 && i < 8));
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step();
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        m0_req = 1'b0; m0_wr = 1'b0; m0_address = '0; m0_dout = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_address = '0; m1_dout = '0;
        test_reset();
        test_handover();
`ifndef BUS_ARBITER_TIMEOUT_EN
        test_simultaneous();
`endif
        test_isolation();
        test_reset_mid_burst();
        test_back_to_back();
`ifdef BUS_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout_watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule
